// File: rtl/llsc_pkg.sv
// llsc_pkg: shared encodings and widths for the LL/SC reservation monitor
package llsc_pkg;
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_LL   = 2'b01;
    localparam logic [1:0] OP_SC   = 2'b10;
    localparam int HOLD_CNT_W = 16;
    typedef enum logic {ST_IDLE = 1'b0, ST_LINKED = 1'b1} llsc_state_t;
endpackage

// File: rtl/llsc_hold_timer.sv
// llsc_hold_timer: clearable saturating reservation age counter with terminal-count flag
module llsc_hold_timer
    import llsc_pkg::*;
#(
    parameter int HOLD_MAX = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  inc,
    output logic [HOLD_CNT_W-1:0] cnt,
    output logic                  tc
);
    assign tc = (HOLD_MAX != 0) && (cnt == HOLD_CNT_W'(HOLD_MAX - 1));
    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/llsc_monitor.sv
// llsc_monitor: owns LLbit and the linked line address, decides SC success in MEM.
// Priority: rst > flush > LL fire > SC fire > snoop hit > timeout > age.
module llsc_monitor
    import llsc_pkg::*;
#(
    parameter int LINE_BITS = 4,
    parameter int HOLD_MAX  = 1023
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  mem_valid,
    input  logic                  mem_stall,
    input  logic [1:0]            mem_op,
    input  logic [31:0]           mem_addr,
    input  logic                  snoop_valid,
    input  logic [31:0]           snoop_addr,
    output logic                  sc_ok,
    output logic                  llbit_o,
    output logic [31:0]           link_addr_o,
    output logic [HOLD_CNT_W-1:0] hold_cnt_o
);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << LINE_BITS) - 32'd1);

    llsc_state_t state, state_n;
    logic fire, is_ll, is_sc, mem_hit, snoop_hit, tc, inc;

    assign fire      = mem_valid & ~mem_stall & ~flush;
    assign is_ll     = fire & (mem_op == OP_LL);
    assign is_sc     = fire & (mem_op == OP_SC);
    assign mem_hit   = ((mem_addr ^ link_addr_o) & LINE_MASK) == '0;
    assign snoop_hit = snoop_valid & (((snoop_addr ^ link_addr_o) & LINE_MASK) == '0);
    assign llbit_o   = state == ST_LINKED;
    assign sc_ok     = mem_valid & ~flush & (mem_op == OP_SC) & llbit_o & mem_hit & ~snoop_hit;

    always_comb begin
        state_n = flush ? ST_IDLE :
                  is_ll ? ST_LINKED :
                  is_sc ? ST_IDLE :
                  (llbit_o && (snoop_hit || tc)) ? ST_IDLE : state;
        inc = llbit_o & ~flush & ~is_ll & ~is_sc & ~snoop_hit & ~tc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            link_addr_o <= '0;
        end else begin
            state <= state_n;
            if (is_ll)
                link_addr_o <= mem_addr & LINE_MASK;
        end
    end

    llsc_hold_timer #(.HOLD_MAX(HOLD_MAX)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (is_ll),
        .inc (inc),
        .cnt (hold_cnt_o),
        .tc  (tc)
    );
endmodule

// File: doc/llsc_monitor.md
# llsc_monitor

Reservation monitor for MIPS LL/SC atomics in the MEM stage. It owns the LLbit and the linked line address, and sequences every change to them: set on LL, test and clear on SC, clear on exception/ERET flush, clear on a matching external write, and clear on a hold timeout. It produces the SC success flag that gates the store and supplies the 0/1 value written to rt. It also exports LLbit and LLAddr to CP0.

## Interface
- LINE_BITS, 4: low address bits ignored in reservation match (16-byte line).
- HOLD_MAX, 1023: cycles a reservation may live before auto-clear; 0 disables timeout.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  exception/ERET from CP0; kills the MEM-stage op and clears the reservation.
- mem_valid  in  1  MEM stage holds a valid instruction.
- mem_stall  in  1  MEM stage stalled this cycle.
- mem_op  in  2  00 none, 01 LL, 10 SC, 11 reserved (treated as none).
- mem_addr  in  32  physical address of the MEM-stage access.
- snoop_valid  in  1  another master writes memory this cycle.
- snoop_addr  in  32  physical address of that write.
- sc_ok  out  1  combinational; MEM-stage SC succeeds (store enable, rt=1).
- llbit_o  out  1  reservation valid.
- link_addr_o  out  32  linked address, line-aligned (low LINE_BITS zero).
- hold_cnt_o  out  16  cycles since link, for debug.

## Operation
- fire = mem_valid & ~mem_stall & ~flush. An op takes effect only on a fire cycle.
- match(a) = a[31:LINE_BITS] == link_addr_o[31:LINE_BITS].
- States are IDLE (llbit_o=0) and LINKED (llbit_o=1).
- Priority per clock edge, highest first:
  - rst: go to IDLE; link_addr_o=0; hold_cnt_o=0.
  - flush: go to IDLE; link_addr_o holds its value.
  - fire LL: go to LINKED; link_addr_o = line-aligned mem_addr; hold_cnt_o=0. This applies from either state, and re-link replaces the old address.
  - fire SC: go to IDLE, whether the SC passes or fails.
  - snoop_valid & match(snoop_addr) while LINKED: go to IDLE.
  - HOLD_MAX≠0 & hold_cnt_o==HOLD_MAX-1 while LINKED: go to IDLE.
  - Otherwise LINKED increments hold_cnt_o, saturating at 0xFFFF. IDLE holds hold_cnt_o.
- sc_ok = mem_valid & ~flush & (mem_op==SC) & llbit_o & match(mem_addr) & ~(snoop_valid & match(snoop_addr)). It is independent of mem_stall, so it stays stable across a stall.
- Same-cycle snoop hit and LL fire: the LL wins and the reservation is set.
- This core's ordinary stores never clear the reservation.
- A stalled LL or SC changes no state.

## Timing
- Every state change is registered. An LL firing in cycle n is visible to an SC in MEM at cycle n+1, with no forwarding path needed.
- sc_ok is zero-latency combinational from the MEM inputs and the current state.
- Timeout: the LL fires at edge n, and llbit_o drops at the edge HOLD_MAX cycles later. With HOLD_MAX=4, llbit_o is high for exactly 4 cycles.
- Outputs after reset: llbit_o=0, link_addr_o=0, hold_cnt_o=0, sc_ok=0.
- rst asserted mid-reservation clears everything at the next edge, regardless of other inputs.

## Structure
- Package llsc_pkg holds:
  - the mem_op encodings (OP_NONE, OP_LL, OP_SC);
  - the state enum (ST_IDLE, ST_LINKED);
  - the HOLD_CNT_W=16 constant.
- One sub-module, llsc_hold_timer: a clearable saturating counter with a terminal-count compare against HOLD_MAX. The parent owns the FSM, the address register and sc_ok.
- The existing standalone LLbit register is replaced by this block; CP0 reads llbit_o and link_addr_o.

## Test plan
- LL 0x1000_0008, then SC 0x1000_000C next cycle → sc_ok=1 in the SC cycle; llbit_o=0 afterwards.
- LL 0x1000_0000, snoop write 0x1000_0004, then SC 0x1000_0000 → sc_ok=0.
- LL 0x1000_0000, snoop write 0x1000_0010, then SC 0x1000_0000 → sc_ok=1, because a different line does not match.
- LL, then flush with mem_valid=1 and mem_op=SC in the same cycle → sc_ok=0, llbit_o=0 next cycle; a following SC fails.
- HOLD_MAX=4: LL, idle 4 cycles → llbit_o drops on the 4th edge after the LL; SC on cycle 5 gives sc_ok=0.
- SC held with mem_stall=1 for 3 cycles → sc_ok=1 throughout and llbit_o=1 until the unstalled fire edge, then 0. Separately, an LL fire with a same-line snoop in the same cycle → llbit_o=1.
